hella_cache_master_engine: RTL and testbench
============================================

Name: hella_cache_master_engine

Overview:
- Synthesizable master-side request/response engine for a Rocket-style HellaCache port.
- Accepts one command at a time on a local valid/ready interface and drives the cache request channel (address, tag, cmd, typ, mask).
- Write data is presented one cycle after the request handshake (s1 data).
- Registers cache responses for the local consumer; a nack raises a sticky kill.
- Sits between a test/accelerator sequencer and the L1 data cache.

Parameters:
- NUM_ADDR_BITS, 32, request address width
- NUM_DATA_BITS, 32, data width; must be a multiple of 8
- NUM_TAG_BITS, 7, request/response tag width

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  local command present
- cmd_ready  out  1  engine can accept a command
- cmd_addr  in  NUM_ADDR_BITS  command address
- cmd_tag  in  NUM_TAG_BITS  command tag
- cmd_cmd  in  5  memory command code
- cmd_typ  in  3  operand size/type
- cmd_data  in  NUM_DATA_BITS  write data
- cmd_mask  in  NUM_DATA_BITS/8  byte mask
- clear_kill  in  1  clears sticky kill
- req_addr  out  NUM_ADDR_BITS  cache request address
- req_ready  in  1  cache accepts request
- req_valid  out  1  request valid
- req_tag  out  NUM_TAG_BITS  request tag
- req_cmd  out  5  request command
- req_typ  out  3  request type
- req_data  out  NUM_DATA_BITS  s1 write data
- req_data_mask  out  NUM_DATA_BITS/8  byte mask
- req_kill  out  1  kill of in-flight request
- rsp_valid  in  1  cache response valid
- rsp_nack  in  1  cache nack
- rsp_tag  in  NUM_TAG_BITS  response tag
- rsp_typ  in  3  response type
- rsp_data  in  NUM_DATA_BITS  response data
- out_valid  out  1  captured response/nack present, one-cycle pulse
- out_nack  out  1  captured nack flag
- out_tag  out  NUM_TAG_BITS  captured tag
- out_typ  out  3  captured type
- out_data  out  NUM_DATA_BITS  captured data

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0; FSM goes to IDLE.
  - cmd_ready is 0 while reset is asserted.
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: register addr/tag/cmd/typ/mask onto req_*, store cmd_data internally, set req_valid=1, go to REQ.
  - req_valid therefore rises the cycle after command acceptance.
- REQ:
  - req_valid=1; req_* held stable until req_ready=1 at a rising edge (handshake).
  - At the handshake edge:
    - req_data takes the stored data.
    - req_addr/req_tag/req_cmd/req_typ/req_data_mask go to 0 and req_valid goes to 0.
    - The kill register clears.
    - FSM goes to GAP.
- GAP: one idle cycle, cmd_ready=0, then IDLE. Minimum command spacing is 3 cycles.
- req_data holds its last value until the next handshake; it is not zeroed.
- Response capture runs every cycle, independent of the FSM:
  - If rsp_valid or rsp_nack is 1: next cycle out_valid=1 and out_nack/out_tag/out_typ/out_data = the sampled inputs.
  - Otherwise out_valid=0 and the other out_* fields hold their values.
- Kill register:
  - Set to 1 on a sampled rsp_nack.
  - Cleared by clear_kill or by a request handshake.
  - Set has priority over both clears in the same cycle.
  - req_kill = kill register.
- rsp_valid and rsp_nack both high: treated as a nack (out_nack=1, kill set).
- reset asserted mid-transaction: the request is dropped immediately; there is no retry.

Optional Feature:
- HELLA_NACK_FAST_KILL_EN:
  - Defined: req_kill = rsp_nack OR kill register, i.e. a combinational same-cycle kill.
  - Undefined: req_kill = kill register only, one-cycle delayed.

Decomposition:
- Package hella_cache_master_pkg holds:
  - FSM state enum (IDLE/REQ/GAP).
  - CMD_W=5, TYP_W=3.
  - Command constants M_XRD=5'd0, M_XWR=5'd1.
  - Typ constants MT_B=0, MT_H=1, MT_W=2, MT_D=3.
- One natural sub-module: hella_cache_rsp_capture, containing the response registers and the kill register.

Test Plan:
- Read with immediate ready:
  - Stimulus: cmd addr=0x1000, tag=5, cmd=0, typ=2, mask=0xF; req_ready=1.
  - Expect: req_valid high for exactly one cycle with those values; all req_* fields 0 the next cycle; cmd_ready returns 2 cycles later.
- Write with backpressure:
  - Stimulus: addr=0x2004, cmd=1, data=0xDEADBEEF; req_ready low for 3 cycles.
  - Expect: req_valid and fields stable 4 cycles; req_data=0xDEADBEEF starting the cycle after the handshake and held afterwards.
- Response capture:
  - Stimulus: rsp_valid=1, tag=5, typ=2, data=0xCAFEF00D for one cycle.
  - Expect: next cycle out_valid=1, out_nack=0 with matching fields; following cycle out_valid=0.
- Nack and kill:
  - Stimulus: rsp_nack=1 (tag=3).
  - Expect: out_nack=1 and req_kill=1 from the next cycle, held; clear_kill pulse drops req_kill; nack and clear_kill in the same cycle keep req_kill=1.
- Reset mid-request:
  - Stimulus: assert reset (0) while in REQ with req_ready=0.
  - Expect: all outputs 0 immediately; after release, cmd_ready=1 in IDLE.
- Fast kill (macro defined):
  - Stimulus: rsp_nack=1.
  - Expect: req_kill=1 in the same cycle.

Source files
------------

// File: rtl/hella_cache_master_pkg.sv
// Shared types and constants for the HellaCache master engine.
package hella_cache_master_pkg;

    localparam int CMD_W = 5;
    localparam int TYP_W = 3;

    // Memory command codes
    localparam logic [CMD_W-1:0] M_XRD = 5'd0;
    localparam logic [CMD_W-1:0] M_XWR = 5'd1;

    // Operand size codes
    localparam logic [TYP_W-1:0] MT_B = 3'd0;
    localparam logic [TYP_W-1:0] MT_H = 3'd1;
    localparam logic [TYP_W-1:0] MT_W = 3'd2;
    localparam logic [TYP_W-1:0] MT_D = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/hella_cache_master_engine_if.sv
// Bundle of the local command, cache request, cache response and captured
// response signals. "master" is the engine side, "slave" the environment.
interface hella_cache_master_engine_if #(
    parameter int NUM_ADDR_BITS = 32,
    parameter int NUM_DATA_BITS = 32,
    parameter int NUM_TAG_BITS  = 7
);
    import hella_cache_master_pkg::*;

    localparam int MASK_W = NUM_DATA_BITS / 8;

    // Local command channel
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [NUM_ADDR_BITS-1:0] cmd_addr;
    logic [NUM_TAG_BITS-1:0]  cmd_tag;
    logic [CMD_W-1:0]         cmd_cmd;
    logic [TYP_W-1:0]         cmd_typ;
    logic [NUM_DATA_BITS-1:0] cmd_data;
    logic [MASK_W-1:0]        cmd_mask;
    logic                     clear_kill;

    // Cache request channel
    logic [NUM_ADDR_BITS-1:0] req_addr;
    logic                     req_ready;
    logic                     req_valid;
    logic [NUM_TAG_BITS-1:0]  req_tag;
    logic [CMD_W-1:0]         req_cmd;
    logic [TYP_W-1:0]         req_typ;
    logic [NUM_DATA_BITS-1:0] req_data;
    logic [MASK_W-1:0]        req_data_mask;
    logic                     req_kill;

    // Cache response channel
    logic                     rsp_valid;
    logic                     rsp_nack;
    logic [NUM_TAG_BITS-1:0]  rsp_tag;
    logic [TYP_W-1:0]         rsp_typ;
    logic [NUM_DATA_BITS-1:0] rsp_data;

    // Captured response for the local consumer
    logic                     out_valid;
    logic                     out_nack;
    logic [NUM_TAG_BITS-1:0]  out_tag;
    logic [TYP_W-1:0]         out_typ;
    logic [NUM_DATA_BITS-1:0] out_data;

    modport master (
        input  cmd_valid, cmd_addr, cmd_tag, cmd_cmd, cmd_typ, cmd_data, cmd_mask, clear_kill,
        input  req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data,
        output cmd_ready, req_addr, req_valid, req_tag, req_cmd, req_typ, req_data,
        output req_data_mask, req_kill, out_valid, out_nack, out_tag, out_typ, out_data
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_tag, cmd_cmd, cmd_typ, cmd_data, cmd_mask, clear_kill,
        output req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data,
        input  cmd_ready, req_addr, req_valid, req_tag, req_cmd, req_typ, req_data,
        input  req_data_mask, req_kill, out_valid, out_nack, out_tag, out_typ, out_data
    );

endinterface

// File: rtl/hella_cache_rsp_capture.sv
// Response capture registers and the sticky kill register.
module hella_cache_rsp_capture
    import hella_cache_master_pkg::*;
#(
    parameter int NUM_DATA_BITS = 32,
    parameter int NUM_TAG_BITS  = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rsp_valid,
    input  logic                     rsp_nack,
    input  logic [NUM_TAG_BITS-1:0]  rsp_tag,
    input  logic [TYP_W-1:0]         rsp_typ,
    input  logic [NUM_DATA_BITS-1:0] rsp_data,
    input  logic                     clear_kill,
    input  logic                     handshake,
    output logic                     out_valid,
    output logic                     out_nack,
    output logic [NUM_TAG_BITS-1:0]  out_tag,
    output logic [TYP_W-1:0]         out_typ,
    output logic [NUM_DATA_BITS-1:0] out_data,
    output logic                     kill
);

    logic rsp_seen;
    assign rsp_seen = rsp_valid | rsp_nack;

    // Register any response or nack; fields hold when nothing arrives.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_nack  <= 1'b0;
            out_tag   <= '0;
            out_typ   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= rsp_seen;
            if (rsp_seen) begin
                out_nack <= rsp_nack;
                out_tag  <= rsp_tag;
                out_typ  <= rsp_typ;
                out_data <= rsp_data;
            end
        end
    end

    // Sticky kill: a nack wins over a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kill <= 1'b0;
        end else if (rsp_nack) begin
            kill <= 1'b1;
        end else if (clear_kill || handshake) begin
            kill <= 1'b0;
        end
    end

endmodule

// File: rtl/hella_cache_master_engine.sv
// HellaCache master engine: accepts one local command at a time, drives the
// cache request channel, presents write data one cycle after the handshake,
// and captures responses. Optional macro HELLA_NACK_FAST_KILL_EN makes
// req_kill follow rsp_nack combinationally in the same cycle.
module hella_cache_master_engine
    import hella_cache_master_pkg::*;
#(
    parameter int NUM_ADDR_BITS = 32,
    parameter int NUM_DATA_BITS = 32,
    parameter int NUM_TAG_BITS  = 7
) (
    input logic                       clock,
    input logic                       reset,
    hella_cache_master_engine_if.master bus
);

    localparam int MASK_W = NUM_DATA_BITS / 8;

    state_e state, state_next;
    logic   idle_ready;
    logic   accept;
    logic   handshake;
    logic   kill;

    logic [NUM_ADDR_BITS-1:0] addr_q;
    logic [NUM_TAG_BITS-1:0]  tag_q;
    logic [CMD_W-1:0]         cmd_q;
    logic [TYP_W-1:0]         typ_q;
    logic [MASK_W-1:0]        mask_q;
    logic [NUM_DATA_BITS-1:0] data_stored;
    logic [NUM_DATA_BITS-1:0] data_s1;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake decode.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        idle_ready = 1'b0;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                idle_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.req_ready) begin
                    handshake  = 1'b1;
                    state_next = GAP;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields load on accept and clear on handshake; s1 data follows.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            tag_q       <= '0;
            cmd_q       <= '0;
            typ_q       <= '0;
            mask_q      <= '0;
            data_stored <= '0;
            data_s1     <= '0;
        end else if (accept) begin
            addr_q      <= bus.cmd_addr;
            tag_q       <= bus.cmd_tag;
            cmd_q       <= bus.cmd_cmd;
            typ_q       <= bus.cmd_typ;
            mask_q      <= bus.cmd_mask;
            data_stored <= bus.cmd_data;
        end else if (handshake) begin
            addr_q      <= '0;
            tag_q       <= '0;
            cmd_q       <= '0;
            typ_q       <= '0;
            mask_q      <= '0;
            data_s1     <= data_stored;
        end
    end

    hella_cache_rsp_capture #(
        .NUM_DATA_BITS (NUM_DATA_BITS),
        .NUM_TAG_BITS  (NUM_TAG_BITS)
    ) u_rsp_capture (
        .clock      (clock),
        .reset      (reset),
        .rsp_valid  (bus.rsp_valid),
        .rsp_nack   (bus.rsp_nack),
        .rsp_tag    (bus.rsp_tag),
        .rsp_typ    (bus.rsp_typ),
        .rsp_data   (bus.rsp_data),
        .clear_kill (bus.clear_kill),
        .handshake  (handshake),
        .out_valid  (bus.out_valid),
        .out_nack   (bus.out_nack),
        .out_tag    (bus.out_tag),
        .out_typ    (bus.out_typ),
        .out_data   (bus.out_data),
        .kill       (kill)
    );

    // cmd_ready is gated by reset because the FSM already sits in IDLE then.
    assign bus.cmd_ready     = reset & idle_ready;
    assign bus.req_valid     = (state == REQ);
    assign bus.req_addr      = addr_q;
    assign bus.req_tag       = tag_q;
    assign bus.req_cmd       = cmd_q;
    assign bus.req_typ       = typ_q;
    assign bus.req_data_mask = mask_q;
    assign bus.req_data      = data_s1;

`ifdef HELLA_NACK_FAST_KILL_EN
    assign bus.req_kill = reset & (bus.rsp_nack | kill);
`else
    assign bus.req_kill = kill;
`endif

endmodule

// File: tb/tb_hella_cache_master_engine.sv
// Self-checking bench for hella_cache_master_engine: directed scenarios plus
// randomized command and response traffic against a transaction-level model.
module tb_hella_cache_master_engine;
    import hella_cache_master_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 7;
    localparam int MW = DW / 8;
    localparam int FW = 1 + AW + TW + CMD_W + TYP_W + MW;

    logic clock;
    logic reset;

    hella_cache_master_engine_if #(
        .NUM_ADDR_BITS (AW),
        .NUM_DATA_BITS (DW),
        .NUM_TAG_BITS  (TW)
    ) bus ();

    hella_cache_master_engine #(
        .NUM_ADDR_BITS (AW),
        .NUM_DATA_BITS (DW),
        .NUM_TAG_BITS  (TW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          exp_kill = 1'b0;
    logic          m_valid  = 1'b0;
    logic          m_nack   = 1'b0;
    logic [TW-1:0] m_tag    = '0;
    logic [2:0]    m_typ    = '0;
    logic [DW-1:0] m_data   = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "bench did not terminate");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [FW-1:0] req_fields();
        return {bus.req_valid, bus.req_addr, bus.req_tag, bus.req_cmd, bus.req_typ, bus.req_data_mask};
    endfunction

    task automatic clear_inputs();
        bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_tag = '0; bus.cmd_cmd = '0;
        bus.cmd_typ = '0;  bus.cmd_data = '0; bus.cmd_mask = '0; bus.clear_kill = 0;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_nack = 0; bus.rsp_tag = '0;
        bus.rsp_typ = '0;  bus.rsp_data = '0;
    endtask

    // One command through accept, hold-under-backpressure, handshake and gap.
    task automatic do_cmd(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                          input logic [4:0] cmd, input logic [2:0] typ,
                          input logic [DW-1:0] data, input logic [MW-1:0] mask,
                          input int delay, input string name);
        int n;
        logic [FW-1:0] exp_f;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_wait got %b exp 1", name, bus.cmd_ready);
        end
        bus.cmd_valid = 1; bus.cmd_addr = addr; bus.cmd_tag = tag; bus.cmd_cmd = cmd;
        bus.cmd_typ = typ; bus.cmd_data = data; bus.cmd_mask = mask; bus.req_ready = 0;
        tick();
        // Scramble the command inputs: the request must come from registers.
        bus.cmd_valid = 0; bus.cmd_addr = $urandom; bus.cmd_tag = TW'($urandom);
        bus.cmd_cmd = 5'($urandom); bus.cmd_typ = 3'($urandom); bus.cmd_data = $urandom;
        bus.cmd_mask = MW'($urandom);
        exp_f = {1'b1, addr, tag, cmd, typ, mask};
        for (int i = 0; i <= delay; i++) begin
            checks++;
            if (req_fields() !== exp_f) begin
                errors++;
                $display("FAIL %s_req_hold cycle %0d got %h exp %h", name, i, req_fields(), exp_f);
            end
            checks++;
            if ({bus.cmd_ready, bus.req_kill} !== {1'b0, exp_kill}) begin
                errors++;
                $display("FAIL %s_busy cycle %0d got ready/kill %b%b exp 0%b",
                         name, i, bus.cmd_ready, bus.req_kill, exp_kill);
            end
            if (i == delay) bus.req_ready = 1;
            tick();
        end
        bus.req_ready = 0;
        exp_kill = 1'b0;
        checks++;
        if ({req_fields(), bus.req_data, bus.cmd_ready, bus.req_kill} !== {{FW{1'b0}}, data, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_after_hs got fields %h data %h ready %b kill %b exp 0 %h 0 0",
                     name, req_fields(), bus.req_data, bus.cmd_ready, bus.req_kill, data);
        end
        // A command offered during the gap cycle must not be taken.
        bus.cmd_valid = 1;
        tick();
        bus.cmd_valid = 0;
        checks++;
        if ({bus.cmd_ready, bus.req_valid, bus.req_data} !== {1'b1, 1'b0, data}) begin
            errors++;
            $display("FAIL %s_gap_end got ready %b valid %b data %h exp 1 0 %h",
                     name, bus.cmd_ready, bus.req_valid, bus.req_data, data);
        end
    endtask

    // One cycle of response-side stimulus, checked against the model.
    task automatic rsp_cycle(input logic v, input logic n, input logic [TW-1:0] tag,
                             input logic [2:0] typ, input logic [DW-1:0] data,
                             input logic clr, input string name);
        logic kexp;
        bus.rsp_valid = v; bus.rsp_nack = n; bus.rsp_tag = tag;
        bus.rsp_typ = typ; bus.rsp_data = data; bus.clear_kill = clr;
`ifdef HELLA_NACK_FAST_KILL_EN
        #1;
        checks++;
        if (bus.req_kill !== (n | exp_kill)) begin
            errors++;
            $display("FAIL %s_fast_kill got %b exp %b", name, bus.req_kill, n | exp_kill);
        end
`endif
        tick();
        if (v || n) begin
            m_valid = 1'b1; m_nack = n; m_tag = tag; m_typ = typ; m_data = data;
        end else begin
            m_valid = 1'b0;
        end
        if (n)        exp_kill = 1'b1;
        else if (clr) exp_kill = 1'b0;
        kexp = exp_kill;
`ifdef HELLA_NACK_FAST_KILL_EN
        kexp = kexp | n;
`endif
        checks++;
        if ({bus.out_valid, bus.out_nack, bus.out_tag, bus.out_typ, bus.out_data} !==
            {m_valid, m_nack, m_tag, m_typ, m_data}) begin
            errors++;
            $display("FAIL %s_out got %b %b %h %h %h exp %b %b %h %h %h", name,
                     bus.out_valid, bus.out_nack, bus.out_tag, bus.out_typ, bus.out_data,
                     m_valid, m_nack, m_tag, m_typ, m_data);
        end
        checks++;
        if (bus.req_kill !== kexp) begin
            errors++;
            $display("FAIL %s_kill got %b exp %b", name, bus.req_kill, kexp);
        end
        bus.rsp_valid = 0; bus.rsp_nack = 0; bus.clear_kill = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #3;
        checks++;
        if ({bus.cmd_ready, bus.req_valid, bus.req_kill, bus.out_valid, bus.req_addr, bus.req_data, bus.out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready %b valid %b kill %b out_valid %b addr %h data %h out_data %h exp all 0",
                     bus.cmd_ready, bus.req_valid, bus.req_kill, bus.out_valid, bus.req_addr, bus.req_data, bus.out_data);
        end
        tick();
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_ready got %b exp 0", bus.cmd_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", bus.cmd_ready);
        end
    endtask

    task automatic test_read();
        do_cmd(32'h0000_1000, 7'd5, M_XRD, MT_W, $urandom, 4'hF, 0, "read");
    endtask

    task automatic test_write_backpressure();
        do_cmd(32'h0000_2004, 7'd9, M_XWR, MT_W, 32'hDEAD_BEEF, 4'hF, 3, "write_bp");
        repeat (2) tick();
        checks++;
        if (bus.req_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_bp_data_hold got %h exp deadbeef", bus.req_data);
        end
    endtask

    task automatic test_rsp_capture();
        rsp_cycle(1'b1, 1'b0, 7'd5, MT_W, 32'hCAFE_F00D, 1'b0, "rsp_capture");
        rsp_cycle(1'b0, 1'b0, 7'd0, 3'd0, 32'h0, 1'b0, "rsp_idle");
    endtask

    task automatic test_nack_kill();
        rsp_cycle(1'b0, 1'b1, 7'd3, MT_B, 32'h1234_5678, 1'b0, "nack");
        rsp_cycle(1'b0, 1'b0, 7'd0, 3'd0, 32'h0, 1'b0, "nack_hold");
        rsp_cycle(1'b0, 1'b0, 7'd0, 3'd0, 32'h0, 1'b1, "clear_kill");
        rsp_cycle(1'b0, 1'b1, 7'd4, MT_H, 32'h0BAD_0BAD, 1'b1, "nack_vs_clear");
        rsp_cycle(1'b1, 1'b1, 7'd6, MT_D, 32'h5555_AAAA, 1'b0, "valid_and_nack");
        // The request handshake clears the kill register.
        do_cmd(32'h0000_3000, 7'd1, M_XRD, MT_B, 32'h0, 4'h1, 1, "kill_by_hs");
    endtask

    task automatic test_random_rsp();
        for (int i = 0; i < 40; i++) begin
            rsp_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      TW'($urandom), 3'($urandom), $urandom,
                      ($urandom_range(0, 3) == 0), "rand_rsp");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_cmd($urandom, TW'($urandom), 5'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                   $urandom, MW'($urandom), $urandom_range(0, 3), "b2b");
        end
    endtask

    task automatic test_reset_mid_request();
        rsp_cycle(1'b0, 1'b1, 7'd2, MT_W, 32'hFEED_FACE, 1'b0, "pre_reset_nack");
        bus.cmd_valid = 1; bus.cmd_addr = 32'h0000_4000; bus.cmd_tag = 7'd8;
        bus.cmd_cmd = M_XWR; bus.cmd_typ = MT_W; bus.cmd_data = 32'h0101_0101; bus.cmd_mask = 4'hF;
        bus.req_ready = 0;
        tick();
        bus.cmd_valid = 0;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({req_fields(), bus.req_data, bus.cmd_ready, bus.req_kill,
             bus.out_valid, bus.out_nack, bus.out_tag, bus.out_typ, bus.out_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid got fields %h data %h ready %b kill %b out %b %b %h %h %h exp all 0",
                     req_fields(), bus.req_data, bus.cmd_ready, bus.req_kill, bus.out_valid,
                     bus.out_nack, bus.out_tag, bus.out_typ, bus.out_data);
        end
        exp_kill = 1'b0; m_valid = 1'b0; m_nack = 1'b0; m_tag = '0; m_typ = '0; m_data = '0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.cmd_ready, bus.req_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_release got ready %b valid %b exp 1 0", bus.cmd_ready, bus.req_valid);
        end
        do_cmd(32'h0000_5008, 7'd10, M_XRD, MT_H, 32'h7777_0000, 4'h3, 2, "post_reset");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_rsp_capture();
        test_nack_kill();
        test_random_rsp();
        test_back_to_back();
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
